fwrisc_uart_prog_loader: RTL and testbench

//  Boot-time program loader for the FPGA top. Consumes the UART receiver byte stream,

---
 rtl/fwrisc_uart_prog_loader_pkg.sv | 24 ++
 rtl/fwrisc_uart_prog_loader_if.sv | 20 ++
 rtl/fwrisc_uart_prog_loader_timeout.sv | 27 ++
 rtl/fwrisc_uart_prog_loader.sv | 154 +++++++++++++++
 tb/tb_fwrisc_uart_prog_loader.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fwrisc_uart_prog_loader_pkg.sv
// Shared types and frame-field constants for the UART program loader.
package fwrisc_uart_prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } loader_state_e;

  localparam logic [7:0] SYNC_BYTE_DEF  = 8'hA5;
  localparam int         LEN_W          = 16;
  localparam int         BYTES_PER_WORD = 4;
  localparam logic [7:0] CSUM_INIT      = 8'h00;

  // The frame is "in flight" from the length bytes up to the checksum byte.
  function automatic logic is_receiving(input loader_state_e s);
    return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/fwrisc_uart_prog_loader_if.sv
// Byte stream in from the UART receiver and word writes out to instruction memory.
interface fwrisc_uart_prog_loader_if #(
  parameter int ADDR_W = 12
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport slave (
    input  rx_valid, rx_data,
    output mem_we, mem_addr, mem_wdata
  );

  modport master (
    output rx_valid, rx_data,
    input  mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/fwrisc_uart_prog_loader_timeout.sv
// Inter-byte watchdog: flags a stalled frame after TIMEOUT_CYC quiet cycles.
module fwrisc_uart_prog_loader_timeout #(
  parameter logic [23:0] TIMEOUT_CYC = 24'd5000000
) (
  input  logic clock,
  input  logic reset,
  input  logic active,
  input  logic kick,
  output logic expired
);
  logic [23:0] cnt_q;

  // A byte arriving on the same edge always wins over expiry.
  assign expired = active && !kick && (cnt_q >= TIMEOUT_CYC - 24'd1);

  // NOTE: reset is synchronous and active-low, so it lives inside the clocked
  // block as an ordinary if-branch, not in the sensitivity list.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (!active || kick) begin
      cnt_q <= '0;
    end else if (!expired) begin
      cnt_q <= cnt_q + 24'd1;
    end
  end
endmodule

// File: rtl/fwrisc_uart_prog_loader.sv
// Parses one framed image from the UART, writes it into imem and releases the core
// only after the checksum verifies.
module fwrisc_uart_prog_loader
  import fwrisc_uart_prog_loader_pkg::*;
#(
  parameter int          MEM_WORDS   = 4096,
  parameter int          ADDR_W      = $clog2(MEM_WORDS),
  parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter logic [23:0] TIMEOUT_CYC = 24'd5000000
) (
  input  logic                       clock,
  input  logic                       reset,
  fwrisc_uart_prog_loader_if.slave   bus,
  output logic                       core_reset_n,
  output logic                       program_receiving,
  output logic                       program_ov,
  output logic                       program_err,
  output logic                       program_done
);

  loader_state_e     state_q, state_d;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  word_idx_q;
  logic [1:0]        byte_idx_q;
  logic [23:0]       buf_q;
  logic [7:0]        csum_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic              ov_q, err_q;

  logic              timed_out;
  logic              set_ov, set_err, restart;
  logic [LEN_W-1:0]  full_len;
  logic              word_end;

  fwrisc_uart_prog_loader_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .active  (is_receiving(state_q)),
    .kick    (bus.rx_valid),
    .expired (timed_out)
  );

  assign full_len = {bus.rx_data, len_q[7:0]};
  assign word_end = bus.rx_valid && (byte_idx_q == 2'(BYTES_PER_WORD - 1));

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    set_ov  = 1'b0;
    set_err = 1'b0;
    restart = 1'b0;
    unique case (state_q)
      ST_IDLE:   if (bus.rx_valid && bus.rx_data == SYNC_BYTE) state_d = ST_LEN_LO;
      ST_LEN_LO: if (bus.rx_valid) state_d = ST_LEN_HI;
      ST_LEN_HI: if (bus.rx_valid) begin
        if ({16'd0, full_len} > 32'(MEM_WORDS)) begin
          state_d = ST_ERR;
          set_ov  = 1'b1;
        end else if (full_len == '0) begin
          state_d = ST_CSUM;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_DATA:   if (word_end && word_idx_q == len_q - 16'd1) state_d = ST_CSUM;
      ST_CSUM:   if (bus.rx_valid) begin
        if (bus.rx_data == csum_q) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_ERR;
          set_err = 1'b1;
        end
      end
      ST_DONE:   state_d = ST_DONE;
      ST_ERR:    if (bus.rx_valid && bus.rx_data == SYNC_BYTE) begin
        state_d = ST_LEN_LO;
        restart = 1'b1;
      end
      default:   state_d = ST_IDLE;
    endcase
    if (timed_out) begin
      state_d = ST_ERR;
      set_err = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      len_q       <= '0;
      word_idx_q  <= '0;
      byte_idx_q  <= '0;
      buf_q       <= '0;
      csum_q      <= CSUM_INIT;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ov_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      unique case (state_q)
        ST_IDLE, ST_ERR: begin
          word_idx_q <= '0;
          byte_idx_q <= '0;
          csum_q     <= CSUM_INIT;
        end
        ST_LEN_LO: if (bus.rx_valid) len_q[7:0] <= bus.rx_data;
        ST_LEN_HI: if (bus.rx_valid) len_q[15:8] <= bus.rx_data;
        ST_DATA: if (bus.rx_valid) begin
          csum_q     <= csum_q + bus.rx_data;
          byte_idx_q <= byte_idx_q + 2'd1;
          // First byte received lands in the least significant lane.
          if (word_end) begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= word_idx_q[ADDR_W-1:0];
            mem_wdata_q <= {bus.rx_data, buf_q};
            word_idx_q  <= word_idx_q + 16'd1;
          end else begin
            buf_q <= {bus.rx_data, buf_q[23:8]};
          end
        end
        default: ;
      endcase
      if (restart) begin
        ov_q  <= 1'b0;
        err_q <= 1'b0;
      end
      if (set_ov)  ov_q  <= 1'b1;
      if (set_err) err_q <= 1'b1;
    end
  end

  assign bus.mem_we         = mem_we_q;
  assign bus.mem_addr       = mem_addr_q;
  assign bus.mem_wdata      = mem_wdata_q;
  assign core_reset_n       = (state_q == ST_DONE);
  assign program_done       = (state_q == ST_DONE);
  assign program_receiving  = is_receiving(state_q);
  assign program_ov         = ov_q;
  assign program_err        = err_q;

endmodule

// File: tb/tb_fwrisc_uart_prog_loader.sv
// Self-checking bench: fixed frame table, hand-written corner sequences, random frames.
module tb_fwrisc_uart_prog_loader;
  localparam int MEM_WORDS = 4096;
  localparam int ADDR_W    = 12;
  localparam int TMO       = 300;

  typedef logic [7:0]  byte_q_t [$];
  typedef logic [31:0] word_q_t [$];

  typedef struct {
    string       name;
    int          nb;
    logic [7:0]  b [12];
    logic        exp_done, exp_err, exp_ov;
    int          exp_nw;
    logic [31:0] w [2];
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fwrisc_uart_prog_loader_if #(.ADDR_W(ADDR_W)) bus ();
  logic core_reset_n, program_receiving, program_ov, program_err, program_done;

  fwrisc_uart_prog_loader #(
    .MEM_WORDS   (MEM_WORDS),
    .ADDR_W      (ADDR_W),
    .SYNC_BYTE   (8'hA5),
    .TIMEOUT_CYC (24'(TMO))
  ) dut (
    .clock             (clk),
    .reset             (rst_n),
    .bus               (bus),
    .core_reset_n      (core_reset_n),
    .program_receiving (program_receiving),
    .program_ov        (program_ov),
    .program_err       (program_err),
    .program_done      (program_done)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  word_q_t wr_addr, wr_data;
  vec_t vecs [4];

  always @(negedge clk) begin
    if (bus.mem_we) begin
      wr_addr.push_back(32'(bus.mem_addr));
      wr_data.push_back(bus.mem_wdata);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_bytes(input byte_q_t q);
    foreach (q[i]) send_byte(q[i], (i == q.size() - 1) ? 0 : $urandom_range(0, 2));
  endtask

  task automatic check_flags(input string tag, input logic done, input logic err, input logic ov);
    check({tag, " done"}, 32'(program_done), 32'(done));
    check({tag, " core_reset_n"}, 32'(core_reset_n), 32'(done));
    check({tag, " err"}, 32'(program_err), 32'(err));
    check({tag, " ov"}, 32'(program_ov), 32'(ov));
    check({tag, " receiving"}, 32'(program_receiving), 32'd0);
  endtask

  task automatic check_writes(input string tag, input word_q_t exp);
    check({tag, " write count"}, 32'(wr_data.size()), 32'(exp.size()));
    foreach (exp[i]) begin
      if (i < wr_data.size()) begin
        check($sformatf("%s addr[%0d]", tag, i), wr_addr[i], 32'(i));
        check($sformatf("%s data[%0d]", tag, i), wr_data[i], exp[i]);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " mem_we"}, 32'(bus.mem_we), 32'd0);
    check({tag, " mem_addr"}, 32'(bus.mem_addr), 32'd0);
    check({tag, " mem_wdata"}, bus.mem_wdata, 32'd0);
    check({tag, " core_reset_n"}, 32'(core_reset_n), 32'd0);
    check({tag, " receiving"}, 32'(program_receiving), 32'd0);
    check({tag, " ov"}, 32'(program_ov), 32'd0);
    check({tag, " err"}, 32'(program_err), 32'd0);
    check({tag, " done"}, 32'(program_done), 32'd0);
  endtask

  // Canonical two-word image: csum 0x13 + 0x6F = 0x82.
  function automatic byte_q_t good_frame();
    byte_q_t q;
    q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h82};
    return q;
  endfunction

  function automatic word_q_t good_words();
    word_q_t q;
    q = '{32'h0000_0013, 32'h0000_006F};
    return q;
  endfunction

  initial begin
    #900us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    byte_q_t bq;
    word_q_t wq;
    int cyc;

    vecs[0] = '{"good", 12, '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h82},
                1'b1, 1'b0, 1'b0, 2, '{32'h13, 32'h6F}};
    vecs[1] = '{"badcsum", 12, '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h83},
                1'b0, 1'b1, 1'b0, 2, '{32'h13, 32'h6F}};
    vecs[2] = '{"overlen", 3, '{8'hA5, 8'h01, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                1'b0, 1'b0, 1'b1, 0, '{32'h0, 32'h0}};
    vecs[3] = '{"garbage_empty", 7, '{8'h00, 8'hFF, 8'h12, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                1'b1, 1'b0, 1'b0, 0, '{32'h0, 32'h0}};

    do_reset();
    check_all_zero("reset");

    // Table of whole frames, each from a fresh reset.
    for (int v = 0; v < 4; v++) begin
      do_reset();
      bq.delete();
      for (int i = 0; i < vecs[v].nb; i++) bq.push_back(vecs[v].b[i]);
      send_bytes(bq);
      if (vecs[v].exp_done)
        check({vecs[v].name, " done next cycle"}, 32'(program_done && core_reset_n), 32'd1);
      repeat (2) @(negedge clk);
      check_flags(vecs[v].name, vecs[v].exp_done, vecs[v].exp_err, vecs[v].exp_ov);
      wq.delete();
      for (int i = 0; i < vecs[v].exp_nw; i++) wq.push_back(vecs[v].w[i]);
      check_writes(vecs[v].name, wq);
    end

    // Overlength recovery: SYNC in ERR clears ov, then the image loads; DONE is final.
    do_reset();
    bq = '{8'hA5, 8'h01, 8'h10};
    send_bytes(bq);
    repeat (2) @(negedge clk);
    check("ov set", 32'(program_ov), 32'd1);
    send_byte(8'hA5, 1);
    check("ov cleared by sync", 32'(program_ov), 32'd0);
    check("receiving after resync", 32'(program_receiving), 32'd1);
    bq = good_frame();
    bq.pop_front();
    send_bytes(bq);
    check("recover done next cycle", 32'(program_done), 32'd1);
    bq = good_frame();
    send_bytes(bq);
    repeat (2) @(negedge clk);
    check_flags("recover", 1'b1, 1'b0, 1'b0);
    check_writes("recover", good_words());

    // Inter-byte timeout inside DATA.
    do_reset();
    bq = '{8'hA5, 8'h01, 8'h00, 8'h13};
    send_bytes(bq);
    cyc = 0;
    while (!program_err && cyc < TMO + 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == TMO / 2) check("receiving mid-silence", 32'(program_receiving), 32'd1);
    end
    check("timeout err", 32'(program_err), 32'd1);
    check("timeout latency in range", 32'(cyc >= TMO - 2 && cyc <= TMO + 2), 32'd1);
    check("timeout receiving", 32'(program_receiving), 32'd0);
    check("timeout core_reset_n", 32'(core_reset_n), 32'd0);
    check("timeout writes", 32'(wr_data.size()), 32'd0);

    // Reset mid-DATA after word 0, rest of the frame arrives while idle.
    do_reset();
    bq = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F};
    send_bytes(bq);
    @(negedge clk);
    check("midreset word0 written", 32'(wr_data.size()), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("midreset");
    rst_n = 1'b1;
    bq = '{8'h00, 8'h00, 8'h00, 8'h82};
    send_bytes(bq);
    repeat (2) @(negedge clk);
    check("midreset no more writes", 32'(wr_data.size()), 32'd1);
    check("midreset not done", 32'(program_done), 32'd0);
    wr_addr.delete();
    wr_data.delete();
    send_bytes(good_frame());
    repeat (2) @(negedge clk);
    check_flags("after midreset", 1'b1, 1'b0, 1'b0);
    check_writes("after midreset", good_words());

    // Random frames against a frame-level model.
    for (int it = 0; it < 24; it++) begin
      int kind, n, ng;
      logic [15:0] n16;
      logic [7:0] sum, g;
      logic [31:0] w;
      do_reset();
      bq.delete();
      wq.delete();
      ng = $urandom_range(0, 3);
      for (int i = 0; i < ng; i++) begin
        g = 8'($urandom_range(0, 255));
        if (g == 8'hA5) g = 8'h5A;
        bq.push_back(g);
      end
      kind = $urandom_range(0, 3);
      n = (kind == 0) ? MEM_WORDS + 1 + $urandom_range(0, 60000) : $urandom_range(0, 6);
      n16 = 16'(n);
      bq.push_back(8'hA5);
      bq.push_back(n16[7:0]);
      bq.push_back(n16[15:8]);
      sum = 8'h00;
      if (kind != 0) begin
        for (int k = 0; k < n; k++) begin
          w = $urandom;
          wq.push_back(w);
          for (int j = 0; j < 4; j++) begin
            bq.push_back(w[8*j +: 8]);
            sum = sum + w[8*j +: 8];
          end
        end
        bq.push_back((kind == 1) ? (sum ^ (8'h01 << $urandom_range(0, 7))) : sum);
      end
      send_bytes(bq);
      repeat (2) @(negedge clk);
      check_flags($sformatf("rand%0d", it), kind >= 2, kind == 1, kind == 0);
      check_writes($sformatf("rand%0d", it), wq);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
